// File: rtl/relu_wb_if.sv
// Bundle of the ReLU write-back start, accumulator-read and memory-write signals.
// master = sequencer side, slave = EAI / accreg / memory side.
interface relu_wb_if;
    logic        relu_ren_st;
    logic [2:0]  relu_acc_id;
    logic [31:0] relu_base_addr;
    logic        acc_ren;
    logic [3:0]  acc_r_pe_id;
    logic [2:0]  acc_r_acc_id;
    logic [31:0] acc_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        relu_busy;
    logic        relu_done;
    logic        relu_start_err;

    modport master (
        input  relu_ren_st, relu_acc_id, relu_base_addr, acc_rd, mem_req_ready,
        output acc_ren, acc_r_pe_id, acc_r_acc_id, mem_req_valid, mem_req_addr,
               mem_req_wdata, relu_busy, relu_done, relu_start_err
    );

    modport slave (
        output relu_ren_st, relu_acc_id, relu_base_addr, acc_rd, mem_req_ready,
        input  acc_ren, acc_r_pe_id, acc_r_acc_id, mem_req_valid, mem_req_addr,
               mem_req_wdata, relu_busy, relu_done, relu_start_err
    );
endinterface

// File: rtl/relu_wb_seq.sv
// Sweeps one accumulator across all PEs, applies ReLU and writes each result to memory.
// state | meaning
// IDLE  | waiting for a start pulse
// RD    | accumulator read strobe for pe_idx
// CAP   | capture relu(acc_rd) into the write-data register
// WR    | hold the memory write until ready
// DONE  | one-cycle completion pulse
module relu_wb_seq #(
    parameter int PE_NUM      = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic     clk,
    input  logic     rst,
    relu_wb_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [3:0]  LAST_PE = 4'(PE_NUM - 1);
    localparam logic [31:0] STRIDE  = 32'(ADDR_STRIDE);

    state_t     state;
    logic [3:0] pe_idx;

    assign bus.acc_r_pe_id = pe_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            pe_idx             <= '0;
            bus.acc_ren        <= 1'b0;
            bus.acc_r_acc_id   <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_wdata  <= '0;
            bus.relu_busy      <= 1'b0;
            bus.relu_done      <= 1'b0;
            bus.relu_start_err <= 1'b0;
        end else begin
            // A start seen in any state but IDLE (DONE included) is a collision.
            bus.relu_start_err <= bus.relu_ren_st && (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.relu_ren_st) begin
                        bus.acc_r_acc_id <= bus.relu_acc_id;
                        bus.mem_req_addr <= bus.relu_base_addr;
                        pe_idx           <= '0;
                        bus.acc_ren      <= 1'b1;
                        bus.relu_busy    <= 1'b1;
                        state            <= RD;
                    end
                end
                RD: begin
                    bus.acc_ren <= 1'b0;
                    state       <= CAP;
                end
                CAP: begin
                    bus.mem_req_wdata <= bus.acc_rd[31] ? 32'd0 : bus.acc_rd;
                    bus.mem_req_valid <= 1'b1;
                    state             <= WR;
                end
                WR: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        if (pe_idx == LAST_PE) begin
                            bus.relu_done <= 1'b1;
                            state         <= DONE;
                        end else begin
                            // Running address instead of a multiply; wraps modulo 2^32.
                            pe_idx           <= pe_idx + 4'd1;
                            bus.mem_req_addr <= bus.mem_req_addr + STRIDE;
                            bus.acc_ren      <= 1'b1;
                            state            <= RD;
                        end
                    end
                end
                DONE: begin
                    bus.relu_done <= 1'b0;
                    bus.relu_busy <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.acc_ren       <= 1'b0;
                    bus.mem_req_valid <= 1'b0;
                    bus.relu_busy     <= 1'b0;
                    bus.relu_done     <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_wb_seq.sv
// Directed bench for relu_wb_seq: accreg model, write/read logging and hand-computed expectations.
`timescale 1ns/1ps
module tb_relu_wb_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   s0     = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   ovl_cnt  = 0;
    logic [31:0] tbl [16];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] rd_id[$];
    logic [31:0] rd_pe[$];

    relu_wb_if bus ();

    relu_wb_seq #(.PE_NUM(16), .ADDR_STRIDE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator register file: data valid exactly one cycle after the read strobe.
    always @(posedge clk)
        bus.acc_rd <= bus.acc_ren ? tbl[bus.acc_r_pe_id] : 32'h0BAD_F00D;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                wr_addr.push_back(bus.mem_req_addr);
                wr_data.push_back(bus.mem_req_wdata);
            end
            if (bus.acc_ren) begin
                rd_id.push_back(32'(bus.acc_r_acc_id));
                rd_pe.push_back(32'(bus.acc_r_pe_id));
            end
            if (bus.relu_done) done_cnt++;
            if (bus.relu_start_err) err_cnt++;
            if (bus.acc_ren && bus.mem_req_valid) ovl_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        rd_id.delete();
        rd_pe.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic set_ramp(input logic [31:0] offs);
        for (int i = 0; i < 16; i++) tbl[i] = offs + 32'(i);
    endtask

    task automatic start_sweep(input logic [2:0] id, input logic [31:0] base);
        bus.relu_acc_id    = id;
        bus.relu_base_addr = base;
        bus.relu_ren_st    = 1'b1;
        s0 = cyc;
        tick();
        bus.relu_ren_st = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int pe);
        logic found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.acc_ren && (bus.acc_r_pe_id == 4'(pe))) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        logic found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.relu_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_acc_ren"},  32'(bus.acc_ren), 32'd0);
        chk({tag, "_pe_id"},    32'(bus.acc_r_pe_id), 32'd0);
        chk({tag, "_acc_id"},   32'(bus.acc_r_acc_id), 32'd0);
        chk({tag, "_valid"},    32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_addr"},     bus.mem_req_addr, 32'd0);
        chk({tag, "_wdata"},    bus.mem_req_wdata, 32'd0);
        chk({tag, "_busy"},     32'(bus.relu_busy), 32'd0);
        chk({tag, "_done"},     32'(bus.relu_done), 32'd0);
        chk({tag, "_err"},      32'(bus.relu_start_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.relu_ren_st    = 1'b0;
        bus.relu_acc_id    = '0;
        bus.relu_base_addr = '0;
        bus.mem_req_ready  = 1'b1;
        set_ramp(32'd0);
        tick();
        tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Sweep 1: PE n returns n-8, ready always high.
        for (int i = 0; i < 16; i++) tbl[i] = 32'(i) - 32'd8;
        clear_logs();
        start_sweep(3'd2, 32'h0000_1000);
        chk("t1_busy_rd", 32'(bus.relu_busy), 32'd1);
        chk("t1_ren_rd", 32'(bus.acc_ren), 32'd1);
        wait_done("t1_done_seen");
        chk("t1_done_cyc", 32'(cyc - s0), 32'd49);
        tick();
        chk("t1_done_pulse", 32'(bus.relu_done), 32'd0);
        chk("t1_busy_idle", 32'(bus.relu_busy), 32'd0);
        chk("t1_nwr", 32'(wr_addr.size()), 32'd16);
        chk("t1_nrd", 32'(rd_id.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            chk($sformatf("t1_addr%0d", i), wr_addr[i], 32'h1000 + 32'(4 * i));
            chk($sformatf("t1_data%0d", i), wr_data[i], (i <= 8) ? 32'd0 : 32'(i - 8));
        end
        for (int i = 0; i < 16 && i < rd_id.size(); i++) begin
            chk($sformatf("t1_rdid%0d", i), rd_id[i], 32'd2);
            chk($sformatf("t1_rdpe%0d", i), rd_pe[i], 32'(i));
        end
        chk("t1_ndone", 32'(done_cnt), 32'd1);

        // Sweep 2: ready low for 5 cycles in PE3's WR.
        set_ramp(32'h100);
        clear_logs();
        start_sweep(3'd7, 32'h0000_1000);
        wait_rd("t2_rd3", 3);
        bus.mem_req_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_valid_c%0d", i), 32'(bus.mem_req_valid), 32'd1);
            chk($sformatf("t2_addr_c%0d", i), bus.mem_req_addr, 32'h100C);
            chk($sformatf("t2_data_c%0d", i), bus.mem_req_wdata, 32'h103);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        chk("t2_valid_c5", 32'(bus.mem_req_valid), 32'd1);
        wait_done("t2_done_seen");
        chk("t2_done_cyc", 32'(cyc - s0), 32'd54);
        tick();
        chk("t2_nwr", 32'(wr_addr.size()), 32'd16);
        if (wr_addr.size() > 3) begin
            chk("t2_wr3_addr", wr_addr[3], 32'h100C);
            chk("t2_wr3_data", wr_data[3], 32'h103);
        end

        // Sweep 3: colliding starts at PE7 and in DONE.
        set_ramp(32'h5000);
        clear_logs();
        start_sweep(3'd1, 32'h0000_3000);
        wait_rd("t3_rd7", 7);
        bus.relu_acc_id    = 3'd5;
        bus.relu_base_addr = 32'h0000_2000;
        bus.relu_ren_st    = 1'b1;
        tick();
        bus.relu_ren_st = 1'b0;
        chk("t3_err_pulse", 32'(bus.relu_start_err), 32'd1);
        chk("t3_id_kept", 32'(bus.acc_r_acc_id), 32'd1);
        tick();
        chk("t3_err_clear", 32'(bus.relu_start_err), 32'd0);
        wait_done("t3_done_seen");
        chk("t3_done_cyc", 32'(cyc - s0), 32'd49);
        bus.relu_acc_id = 3'd6;
        bus.relu_ren_st = 1'b1;
        tick();
        bus.relu_ren_st = 1'b0;
        chk("t3_err_in_done", 32'(bus.relu_start_err), 32'd1);
        chk("t3_idle_after_done", 32'(bus.relu_busy), 32'd0);
        tick();
        chk("t3_no_restart", 32'(bus.relu_busy), 32'd0);
        chk("t3_no_ren", 32'(bus.acc_ren), 32'd0);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            chk($sformatf("t3_addr%0d", i), wr_addr[i], 32'h3000 + 32'(4 * i));
            chk($sformatf("t3_data%0d", i), wr_data[i], 32'h5000 + 32'(i));
        end
        for (int i = 0; i < rd_id.size(); i++)
            chk($sformatf("t3_rdid%0d", i), rd_id[i], 32'd1);
        chk("t3_ndone", 32'(done_cnt), 32'd1);
        chk("t3_nerr", 32'(err_cnt), 32'd2);

        // Sweep 4: reset during PE5's CAP, with a start in the reset cycle.
        set_ramp(32'h7000);
        clear_logs();
        start_sweep(3'd3, 32'h0000_4000);
        wait_rd("t4_rd5", 5);
        tick();
        rst = 1'b1;
        bus.relu_ren_st = 1'b1;
        tick();
        rst = 1'b0;
        bus.relu_ren_st = 1'b0;
        chk_outputs_zero("t4_abort");
        repeat (60) tick();
        chk("t4_nwr", 32'(wr_addr.size()), 32'd5);
        chk("t4_nrd", 32'(rd_id.size()), 32'd6);
        chk("t4_ndone", 32'(done_cnt), 32'd0);
        chk("t4_busy", 32'(bus.relu_busy), 32'd0);

        // Sweep 5: address wrap and ReLU sign boundaries.
        set_ramp(32'd0);
        tbl[0] = 32'h8000_0000;
        tbl[1] = 32'h7FFF_FFFF;
        tbl[2] = 32'h1234_5678;
        tbl[3] = 32'hFFFF_FFFF;
        clear_logs();
        start_sweep(3'd4, 32'hFFFF_FFF8);
        wait_done("t5_done_seen");
        tick();
        chk("t5_nwr", 32'(wr_addr.size()), 32'd16);
        if (wr_addr.size() == 16) begin
            chk("t5_addr0", wr_addr[0], 32'hFFFF_FFF8);
            chk("t5_addr1", wr_addr[1], 32'hFFFF_FFFC);
            chk("t5_addr2_wrap", wr_addr[2], 32'h0000_0000);
            chk("t5_addr3", wr_addr[3], 32'h0000_0004);
            chk("t5_addr15", wr_addr[15], 32'h0000_0034);
            chk("t5_data_min", wr_data[0], 32'h0000_0000);
            chk("t5_data_max", wr_data[1], 32'h7FFF_FFFF);
            chk("t5_data2", wr_data[2], 32'h1234_5678);
            chk("t5_data_m1", wr_data[3], 32'h0000_0000);
            chk("t5_data15", wr_data[15], 32'd15);
        end

        chk("no_ren_valid_overlap", 32'(ovl_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/relu_wb_seq.md
RELU_WB_SEQ -- requirements
Module: relu_wb_seq

Interface
REQ-001 Parameter PE_NUM, default 16, number of PE accumulators swept per ReLU write-back.
REQ-002 Parameter ADDR_STRIDE, default 4, byte increment of the memory address per PE.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 relu_ren_st  input  1  start pulse: the ReLU write-back instruction was accepted on the EAI handshake.
REQ-006 relu_acc_id  input  3  accumulator index; sampled with the start pulse.
REQ-007 relu_base_addr  input  32  destination byte base address (rs1_data); sampled with the start pulse.
REQ-008 acc_ren  output  1  accumulator read enable to the PE accreg.
REQ-009 acc_r_pe_id  output  4  PE index being read.
REQ-010 acc_r_acc_id  output  3  accumulator index being read.
REQ-011 acc_rd  input  32  accumulator read data; valid exactly 1 cycle after acc_ren.
REQ-012 mem_req_valid  output  1  memory write request valid.
REQ-013 mem_req_ready  input  1  memory write request ready.
REQ-014 mem_req_addr  output  32  write byte address.
REQ-015 mem_req_wdata  output  32  write data after ReLU.
REQ-016 relu_busy  output  1  sweep in progress.
REQ-017 relu_done  output  1  one-cycle completion pulse, consumed as the long-op done for the EAI response.
REQ-018 relu_start_err  output  1  one-cycle pulse: a start arrived while busy.

Function
REQ-019 FSM states SHALL be IDLE, RD, CAP, WR and DONE.
REQ-020 IDLE with relu_ren_st=1 SHALL latch acc_id, base_addr and pe_idx=0, then go to RD.
REQ-021 RD SHALL assert acc_ren=1 with acc_r_pe_id=pe_idx and acc_r_acc_id=latched id for exactly one cycle, then go to CAP.
REQ-022 CAP SHALL register relu(acc_rd) into the write-data register, then go to WR.
REQ-023 relu(x) SHALL output 0 when x[31]=1 (signed negative, including 0x80000000) and x unchanged otherwise.
REQ-024 WR SHALL hold mem_req_valid=1 with stable addr and wdata until mem_req_ready=1 is seen on the same edge.
REQ-025 mem_req_addr SHALL equal base_addr + pe_idx*ADDR_STRIDE, modulo 2^32 (wrap silently).
REQ-026 A handshake with pe_idx<PE_NUM-1 SHALL increment pe_idx and go to RD; with pe_idx=PE_NUM-1 it SHALL go to DONE.
REQ-027 DONE SHALL assert relu_done=1 for one cycle, then go to IDLE.
REQ-028 relu_busy SHALL be 1 in RD, CAP, WR and DONE, and 0 in IDLE.
REQ-029 relu_ren_st outside IDLE SHALL be ignored (no state or latch change) and SHALL pulse relu_start_err the next cycle.
REQ-030 relu_ren_st in DONE SHALL also count as busy; back-to-back sweeps therefore need at least 1 IDLE cycle.
REQ-031 With ready held at 1, a sweep SHALL take 3*PE_NUM cycles plus 1 DONE cycle (49 cycles for PE_NUM=16).
REQ-032 acc_ren and mem_req_valid SHALL never be asserted in the same cycle.
REQ-033 All outputs SHALL be registered or decoded from state registers only, with no combinational path from the inputs.

Reset
REQ-034 rst=1 SHALL force IDLE and pe_idx=0, and set acc_ren, mem_req_valid, relu_busy, relu_done and relu_start_err to 0.
REQ-035 rst=1 SHALL set acc_r_pe_id, acc_r_acc_id, mem_req_addr and mem_req_wdata to 0.
REQ-036 rst mid-sweep SHALL abort the sweep: any pending write is dropped, no relu_done is issued, and relu_ren_st in the rst cycle is ignored.

Verification
REQ-037 Bench SHALL cover: start at cycle 0 (acc_id=2, base=0x1000, ready=1, PE n returns n-8) -> 16 writes to 0x1000..0x103C; data 0 for PE0..8 and 1..7 for PE9..15; relu_done at cycle 49.
REQ-038 Bench SHALL cover: ready low for 5 cycles at PE3's WR -> valid, addr 0x100C and data held stable for 5 cycles; sweep completes 5 cycles later.
REQ-039 Bench SHALL cover: start pulse while busy at PE7 -> relu_start_err pulse; sweep and latched id/base unchanged; exactly one relu_done.
REQ-040 Bench SHALL cover: rst asserted during PE5's CAP -> next cycle all outputs 0, no further writes, no relu_done.
REQ-041 Bench SHALL cover: base=0xFFFFFFF8 -> PE2 address 0x00000000 (wrap); acc_rd 0x80000000 -> wdata 0; acc_rd 0x7FFFFFFF -> passed unchanged.
